pc_exception_unit: RTL and testbench
====================================

Name: pc_exception_unit

Overview:
- Owns the architectural PC, EPC and Cause registers of the multicycle MIPS datapath.
- Sits directly downstream of the control unit and consumes its EscrevePC / EscrevePCCondEQ / EscrevePCCondNE / OrigPC / CauseWrite / IntCause outputs.
- Resolves conditional branch writes against the ALU Zero flag.
- Runs the exception-vector sequence: saves EPC and Cause, reads the handler byte from memory after a fixed latency, and loads it into PC.

Parameters:
- WIDTH, 32, datapath width.
- MEM_LAT, 2, memory read latency in cycles (minimum 1).
- VEC_BASE, 253, byte address of the vector table; entry address = VEC_BASE + cause code.
- RESET_PC, 0, PC value after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- EscrevePC  in  1  unconditional PC write.
- EscrevePCCondEQ  in  1  PC write if Zero=1.
- EscrevePCCondNE  in  1  PC write if Zero=0.
- OrigPC  in  2  next-PC source: 00 AluResult, 01 AluOut, 10 jump target, 11 EPC.
- Zero  in  1  ALU zero flag.
- AluResult  in  WIDTH  combinational ALU output.
- AluOut  in  WIDTH  ALUOut register.
- JumpField  in  26  IR[25:0].
- CauseWrite  in  1  exception request pulse from the control unit.
- IntCause  in  1  0 = nonexistent opcode, 1 = overflow.
- MemByte  in  8  memory read data, low byte.
- PC  out  WIDTH  program counter.
- EPC  out  WIDTH  exception PC.
- Cause  out  WIDTH  cause code, zero-extended.
- ExcAddr  out  WIDTH  vector-table address; valid while ExcBusy=1.
- ExcBusy  out  1  exception sequence in progress; the memory address mux must select ExcAddr.
- ExcDone  out  1  one-cycle pulse when the handler address has been loaded into PC.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC; EPC=0; Cause=0; state=IDLE; counter=0.
  - ExcBusy=0; ExcDone=0; ExcAddr=0.
  - Deasserting reset mid-sequence resumes in IDLE; no partial EPC/Cause update survives.
- PC write enable: pc_wr = EscrevePC | (EscrevePCCondEQ & Zero) | (EscrevePCCondNE & ~Zero). PC updates at the clock edge while in IDLE.
- Jump target: {PC[31:28], JumpField, 2'b00}. OrigPC=11 loads the EPC register value.
- FSM states: IDLE, WAIT, LOAD.
  - IDLE, CauseWrite=1: EPC<=PC-4 (modulo 2^WIDTH); Cause<=IntCause; counter<=MEM_LAT-1; go to WAIT. Any PC write in the same cycle is suppressed (exception wins).
  - WAIT: ExcBusy=1; ExcAddr=VEC_BASE+Cause. Decrement the counter; go to LOAD when counter=0.
  - LOAD: ExcBusy=1; ExcDone=1; PC<={24'b0, MemByte}; go to IDLE.
- While not IDLE:
  - All PC-write inputs are ignored.
  - CauseWrite is ignored (no nesting); EPC and Cause are held.
- Latency: with request in cycle 0, PC holds the handler at cycle MEM_LAT+2 and ExcDone is high in cycle MEM_LAT+1.
- Outside exceptions, EPC and Cause are written only by the sequence above. ExcAddr=0 when IDLE.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A PC write from source 00 or 01 whose value has bits [1:0]≠0 is not performed.
  - Instead an exception starts with Cause=2: EPC<=PC-4, vector address VEC_BASE+2.
  - Output AlignFault (1 bit) pulses in that cycle.
  - An explicit CauseWrite in the same cycle takes priority and is handled normally.
- Undefined: misaligned values are written to PC unchanged; no AlignFault port exists.

Decomposition:
- Shared package pc_exc_pkg holds:
  - OrigPC source enum.
  - Cause code constants: CAUSE_OPCODE=0, CAUSE_OVF=1, CAUSE_ALIGN=2.
  - FSM state enum.
- One sub-module, exc_sequencer, contains the IDLE/WAIT/LOAD FSM and latency counter and outputs the busy, done and load strobes.
- The top level holds the registers and the next-PC mux.

Test Plan:
- Reset with PC=0x40, then release; EscrevePC=1, OrigPC=00, AluResult=0x4 -> PC=0x4 on the next edge.
- PC=0x100, EscrevePCCondEQ=1, OrigPC=01, AluOut=0x200: with Zero=0 PC stays 0x100; with Zero=1 PC becomes 0x200. Repeat with CondNE and inverted outcomes.
- PC=0x10, CauseWrite=1, IntCause=1, MEM_LAT=2, MemByte=0x80:
  - EPC=0xC; Cause=1.
  - ExcAddr=254 with ExcBusy high for 3 cycles.
  - ExcDone pulses at cycle 3; PC=0x80.
  - A simultaneous EscrevePC is ignored.
- Mid-sequence, CauseWrite=1 with IntCause=0 and EscrevePC=1 -> EPC, Cause and PC unchanged until LOAD. Assert reset in WAIT -> all registers cleared and ExcBusy=0.
- Return from exception: after the sequence above, OrigPC=11 with EscrevePC=1 -> PC=0xC.
- With PC_ALIGN_CHECK_EN: EscrevePC with AluResult=0x6 -> PC not written, AlignFault pulses, Cause=2, ExcAddr=255.

Source files
------------

// File: rtl/pc_exc_pkg.sv
// Shared types and constants for the PC / exception unit.
package pc_exc_pkg;

  // Next-PC source select driven by the control unit
  typedef enum logic [1:0] {
    SRC_ALU_RESULT = 2'b00,
    SRC_ALU_OUT    = 2'b01,
    SRC_JUMP       = 2'b10,
    SRC_EPC        = 2'b11
  } orig_pc_e;

  // Exception cause codes (also the vector-table offset)
  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;
  localparam logic [1:0] CAUSE_ALIGN  = 2'd2;

  // Exception sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } exc_state_e;

endpackage

// File: rtl/exc_sequencer.sv
// Exception-vector sequencer: IDLE -> WAIT (memory latency) -> LOAD -> IDLE.
module exc_sequencer
  import pc_exc_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic load_o
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  exc_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  // State, latency counter and registered strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      load_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_o <= 1'b0;
          load_o <= 1'b0;
          if (start_i) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            busy_o  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_LOAD;
            done_o  <= 1'b1;
            load_o  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_LOAD: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          load_o  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          load_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_exception_unit.sv
// PC, EPC and Cause registers of the multicycle MIPS datapath with
// branch resolution and the exception-vector load sequence.
// Optional macro PC_ALIGN_CHECK_EN: misaligned ALU-sourced PC writes raise
// an alignment exception (Cause=2) and pulse AlignFault.
module pc_exception_unit
  import pc_exc_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned VEC_BASE = 253,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EscrevePC,
  input  logic             EscrevePCCondEQ,
  input  logic             EscrevePCCondNE,
  input  logic [1:0]       OrigPC,
  input  logic             Zero,
  input  logic [WIDTH-1:0] AluResult,
  input  logic [WIDTH-1:0] AluOut,
  input  logic [25:0]      JumpField,
  input  logic             CauseWrite,
  input  logic             IntCause,
  input  logic [7:0]       MemByte,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] EPC,
  output logic [WIDTH-1:0] Cause,
  output logic [WIDTH-1:0] ExcAddr,
  output logic             ExcBusy,
  output logic             ExcDone
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             AlignFault
`endif
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] cause_q, cause_d;
  logic [WIDTH-1:0] exc_addr_q, exc_addr_d;
  logic [WIDTH-1:0] next_pc;
  logic [1:0]       exc_cause;
  logic             pc_wr, do_pc_wr, exc_req, start, busy, done, load;
  logic             misalign;

  exc_sequencer #(.MEM_LAT(MEM_LAT)) u_seq (
    .clock   (clock),
    .reset   (reset),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .load_o  (load)
  );

  // Branch resolution, next-PC mux and exception request selection
  always_comb begin
    pc_wr = EscrevePC | (EscrevePCCondEQ & Zero) | (EscrevePCCondNE & ~Zero);
    next_pc = AluResult;
    case (orig_pc_e'(OrigPC))
      SRC_ALU_RESULT: next_pc = AluResult;
      SRC_ALU_OUT:    next_pc = AluOut;
      SRC_JUMP:       next_pc = {pc_q[WIDTH-1:28], JumpField, 2'b00};
      SRC_EPC:        next_pc = epc_q;
    endcase
`ifdef PC_ALIGN_CHECK_EN
    misalign = pc_wr & ~OrigPC[1] & (next_pc[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    exc_req   = CauseWrite | misalign;
    exc_cause = CauseWrite ? (IntCause ? CAUSE_OVF : CAUSE_OPCODE) : CAUSE_ALIGN;
    do_pc_wr  = pc_wr & ~misalign;
    start     = exc_req & ~busy;
  end

`ifdef PC_ALIGN_CHECK_EN
  // Fault pulse only when the alignment check itself launches the exception
  assign AlignFault = misalign & ~busy & ~CauseWrite;
`endif

  // Next values of the architectural registers; the exception always wins
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    exc_addr_d = exc_addr_q;
    if (start) begin
      epc_d      = pc_q - WIDTH'(4);
      cause_d    = WIDTH'(exc_cause);
      exc_addr_d = WIDTH'(VEC_BASE) + WIDTH'(exc_cause);
    end else if (load) begin
      pc_d       = {{(WIDTH-8){1'b0}}, MemByte};
      exc_addr_d = '0;
    end else if (!busy && do_pc_wr) begin
      pc_d = next_pc;
    end
  end

  // Architectural register state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= WIDTH'(RESET_PC);
      epc_q      <= '0;
      cause_q    <= '0;
      exc_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign PC      = pc_q;
  assign EPC     = epc_q;
  assign Cause   = cause_q;
  assign ExcAddr = exc_addr_q;
  assign ExcBusy = busy;
  assign ExcDone = done;

endmodule

// File: tb/tb_pc_exception_unit.sv
// Self-checking bench for pc_exception_unit (default parameters).
module tb_pc_exception_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        EscrevePC, EscrevePCCondEQ, EscrevePCCondNE;
  logic [1:0]  OrigPC;
  logic        Zero;
  logic [31:0] AluResult, AluOut;
  logic [25:0] JumpField;
  logic        CauseWrite, IntCause;
  logic [7:0]  MemByte;
  logic [31:0] PC, EPC, Cause, ExcAddr;
  logic        ExcBusy, ExcDone;
`ifdef PC_ALIGN_CHECK_EN
  logic        AlignFault;
`endif

  pc_exception_unit dut (
    .clock           (clock),
    .reset           (reset),
    .EscrevePC       (EscrevePC),
    .EscrevePCCondEQ (EscrevePCCondEQ),
    .EscrevePCCondNE (EscrevePCCondNE),
    .OrigPC          (OrigPC),
    .Zero            (Zero),
    .AluResult       (AluResult),
    .AluOut          (AluOut),
    .JumpField       (JumpField),
    .CauseWrite      (CauseWrite),
    .IntCause        (IntCause),
    .MemByte         (MemByte),
    .PC              (PC),
    .EPC             (EPC),
    .Cause           (Cause),
    .ExcAddr         (ExcAddr),
    .ExcBusy         (ExcBusy),
    .ExcDone         (ExcDone)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .AlignFault      (AlignFault)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc, epc, cause, addr;
    logic        busy, done;
  } obs_t;

  typedef struct {
    logic        wr, eq, ne;
    logic [1:0]  src;
    logic        zero;
    logic [31:0] res, out;
    logic [25:0] jf;
    logic [31:0] exp_pc;
  } vec_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] addr, input logic busy, input logic done);
    obs_t e;
    e.pc = pc; e.epc = epc; e.cause = cause; e.addr = addr; e.busy = busy; e.done = done;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    obs_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty actual=0 expected=1", tag);
    end else begin
      checks--;
      e = sb_q.pop_front();
      chk({tag, ".pc"}, PC, e.pc);
      chk({tag, ".epc"}, EPC, e.epc);
      chk({tag, ".cause"}, Cause, e.cause);
      chk({tag, ".addr"}, ExcAddr, e.addr);
      chk({tag, ".busy"}, 32'(ExcBusy), 32'(e.busy));
      chk({tag, ".done"}, 32'(ExcDone), 32'(e.done));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    EscrevePC = 0; EscrevePCCondEQ = 0; EscrevePCCondNE = 0;
    OrigPC = 2'b00; Zero = 0; AluResult = '0; AluOut = '0; JumpField = '0;
    CauseWrite = 0; IntCause = 0;
  endtask

  vec_t vecs[14];

  initial begin
    idle_inputs();
    MemByte = 8'h80;
    reset = 1'b0;
    tick(); tick();
    push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    pop_chk("reset_state");
    reset = 1'b1;
    tick();

    // Move PC to 0x40 then reset again
    EscrevePC = 1; AluResult = 32'h40;
    push_exp(32'h40, 0, 0, 0, 0, 0);
    tick(); pop_chk("pc_0x40");
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    push_exp(32'h0, 0, 0, 0, 0, 0);
    pop_chk("reset_from_0x40");
    tick();
    reset = 1'b1;
    tick();

    //          wr eq ne src    z  res           out           jf          exp_pc
    vecs[0]  = '{1, 0, 0, 2'b00, 0, 32'h4,        32'h0,        26'h0,      32'h4};
    vecs[1]  = '{1, 0, 0, 2'b01, 0, 32'h0,        32'h100,      26'h0,      32'h100};
    vecs[2]  = '{0, 1, 0, 2'b01, 0, 32'h0,        32'h200,      26'h0,      32'h100};
    vecs[3]  = '{0, 1, 0, 2'b01, 1, 32'h0,        32'h200,      26'h0,      32'h200};
    vecs[4]  = '{1, 0, 0, 2'b00, 0, 32'h100,      32'h0,        26'h0,      32'h100};
    vecs[5]  = '{0, 0, 1, 2'b01, 1, 32'h0,        32'h200,      26'h0,      32'h100};
    vecs[6]  = '{0, 0, 1, 2'b01, 0, 32'h0,        32'h200,      26'h0,      32'h200};
    vecs[7]  = '{0, 0, 0, 2'b00, 0, 32'h55,       32'h66,       26'h0,      32'h200};
    vecs[8]  = '{1, 0, 0, 2'b10, 0, 32'h0,        32'h0,        26'h0000123, 32'h0000048C};
    vecs[9]  = '{1, 0, 0, 2'b00, 0, 32'hF0000000, 32'h0,        26'h0,      32'hF0000000};
    vecs[10] = '{1, 0, 0, 2'b10, 0, 32'h0,        32'h0,        26'h3FFFFFF, 32'hFFFFFFFC};
    vecs[11] = '{0, 1, 1, 2'b00, 0, 32'h10,       32'h0,        26'h0,      32'h10};
    vecs[12] = '{1, 0, 0, 2'b11, 0, 32'h0,        32'h0,        26'h0,      32'h0};
    vecs[13] = '{1, 0, 0, 2'b00, 0, 32'h10,       32'h0,        26'h0,      32'h10};

    for (int i = 0; i < 14; i++) begin
      EscrevePC = vecs[i].wr; EscrevePCCondEQ = vecs[i].eq; EscrevePCCondNE = vecs[i].ne;
      OrigPC = vecs[i].src; Zero = vecs[i].zero;
      AluResult = vecs[i].res; AluOut = vecs[i].out; JumpField = vecs[i].jf;
      push_exp(vecs[i].exp_pc, 0, 0, 0, 0, 0);
      tick();
      pop_chk($sformatf("vec%0d", i));
    end
    idle_inputs();

    // Exception from PC=0x10 with a competing EscrevePC in the request cycle
    CauseWrite = 1; IntCause = 1; EscrevePC = 1; AluResult = 32'h44;
    push_exp(32'h10, 32'hC, 32'h1, 32'd254, 1, 0);
    tick(); pop_chk("exc_c1");
    // Mid-sequence requests and PC writes must be ignored
    CauseWrite = 1; IntCause = 0; EscrevePC = 1; AluResult = 32'h99;
    push_exp(32'h10, 32'hC, 32'h1, 32'd254, 1, 0);
    tick(); pop_chk("exc_c2");
    push_exp(32'h10, 32'hC, 32'h1, 32'd254, 1, 1);
    tick(); pop_chk("exc_c3_load");
    push_exp(32'h80, 32'hC, 32'h1, 32'h0, 0, 0);
    tick(); pop_chk("exc_c4_handler");
    idle_inputs();

    // Return from exception
    EscrevePC = 1; OrigPC = 2'b11;
    push_exp(32'hC, 32'hC, 32'h1, 32'h0, 0, 0);
    tick(); pop_chk("eret");
    idle_inputs();

    // Reset asserted while in WAIT
    CauseWrite = 1; IntCause = 0;
    push_exp(32'hC, 32'h8, 32'h0, 32'd253, 1, 0);
    tick(); pop_chk("exc2_wait");
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    push_exp(32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    pop_chk("reset_in_wait");
    tick();
    reset = 1'b1;
    push_exp(32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    tick(); pop_chk("after_reset_idle");
    push_exp(32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    tick(); pop_chk("after_reset_idle2");

`ifdef PC_ALIGN_CHECK_EN
    // Misaligned ALU-sourced write launches an alignment exception
    EscrevePC = 1; OrigPC = 2'b00; AluResult = 32'h6;
    #1;
    chk("align_fault_pulse", 32'(AlignFault), 32'h1);
    push_exp(32'h0, 32'hFFFFFFFC, 32'h2, 32'd255, 1, 0);
    tick(); pop_chk("align_c1");
    idle_inputs();
    chk("align_fault_low", 32'(AlignFault), 32'h0);
    tick(); tick(); tick();
    push_exp(32'h80, 32'hFFFFFFFC, 32'h2, 32'h0, 0, 0);
    pop_chk("align_handler");
`endif

    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
